// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the unified memory port arbiter.
// FSM states and access-owner codes used by the arbiter and its bench.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory signals of the unified memory port.
// The arbiter takes the slave view; the CPU/memory side takes the master view.
interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);

  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_ack;
  logic [DW-1:0] if_rdata;

  logic          dm_req;
  logic          dm_we;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic          dm_ack;
  logic [DW-1:0] dm_rdata;

  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ready;

  logic          err;

  modport slave (
    input  if_req, if_addr,
    input  dm_req, dm_we, dm_addr, dm_wdata,
    input  mem_rdata, mem_ready,
    output if_ack, if_rdata,
    output dm_ack, dm_rdata,
    output mem_req, mem_we, mem_addr, mem_wdata,
    output err
  );

  modport master (
    output if_req, if_addr,
    output dm_req, dm_we, dm_addr, dm_wdata,
    output mem_rdata, mem_ready,
    input  if_ack, if_rdata,
    input  dm_ack, dm_rdata,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    input  err
  );

endinterface

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter: DM over IF with a starvation guard on IF,
// variable-latency handshake and a timeout that aborts a stuck access.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 16
) (
  input logic CLK,
  input logic RST,
  mem_port_arbiter_if.slave bus
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int WW = $clog2(TIMEOUT);

  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [WW-1:0] WAIT_LAST  = WW'(TIMEOUT - 1);

  state_e        state_q, state_d;
  owner_e        owner_q, owner_d;
  logic [SW-1:0] starve_q, starve_d;
  logic [WW-1:0] wait_q, wait_d;

  logic          mem_req_q, mem_req_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;

  logic          if_ack_q, if_ack_d;
  logic          dm_ack_q, dm_ack_d;
  logic          err_q, err_d;
  logic [DW-1:0] if_rdata_q, if_rdata_d;
  logic [DW-1:0] dm_rdata_q, dm_rdata_d;

  logic          gnt_dm;
  logic          gnt_if;

  // IF is forced through once DM has won STARVE_LIMIT times in a row.
  assign gnt_dm = bus.dm_req &&
                  !(bus.if_req && starve_q == STARVE_MAX);
  assign gnt_if = !gnt_dm && bus.if_req;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      owner_q     <= OWN_IF;
      starve_q    <= '0;
      wait_q      <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_ack_q    <= 1'b0;
      dm_ack_q    <= 1'b0;
      err_q       <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      starve_q    <= starve_d;
      wait_q      <= wait_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_ack_q    <= if_ack_d;
      dm_ack_q    <= dm_ack_d;
      err_q       <= err_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    starve_d    = starve_q;
    wait_d      = wait_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_ack_d    = 1'b0;
    dm_ack_d    = 1'b0;
    err_d       = 1'b0;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;

    unique case (state_q)
      ST_IDLE: begin
        if (gnt_dm && bus.if_req) begin
          if (starve_q != STARVE_MAX) starve_d = starve_q + SW'(1);
        end else begin
          starve_d = '0;
        end
        if (gnt_dm || gnt_if) begin
          state_d     = ST_BUSY;
          owner_d     = gnt_dm ? OWN_DM : OWN_IF;
          wait_d      = '0;
          mem_req_d   = 1'b1;
          mem_we_d    = gnt_dm && bus.dm_we;
          mem_addr_d  = gnt_dm ? bus.dm_addr : bus.if_addr;
          mem_wdata_d = (gnt_dm && bus.dm_we) ? bus.dm_wdata : '0;
        end
      end

      ST_BUSY: begin
        wait_d = wait_q + WW'(1);
        if (bus.mem_ready || wait_q == WAIT_LAST) begin
          state_d     = ST_RESP;
          mem_req_d   = 1'b0;
          mem_we_d    = 1'b0;
          mem_addr_d  = '0;
          mem_wdata_d = '0;
          if_ack_d    = (owner_q == OWN_IF);
          dm_ack_d    = (owner_q == OWN_DM);
          err_d       = !bus.mem_ready;
          if (bus.mem_ready && !mem_we_q) begin
            if (owner_q == OWN_IF) if_rdata_d = bus.mem_rdata;
            else                   dm_rdata_d = bus.mem_rdata;
          end
        end
      end

      ST_RESP: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.if_ack    = if_ack_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.dm_ack    = dm_ack_q;
  assign bus.dm_rdata  = dm_rdata_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: hand-computed vectors,
// the bench itself plays requesters and memory.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.AW(32), .DW(32)) bus();

  mem_port_arbiter #(
    .AW(32),
    .DW(32),
    .STARVE_LIMIT(4),
    .TIMEOUT(16)
  ) dut (
    .CLK(clk),
    .RST(rst),
    .bus(bus)
  );

  int n_vec  = 0;
  int n_miss = 0;

  logic [31:0] exp_if_rd = '0;
  logic [31:0] exp_dm_rd = '0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, ".mreq"}, 32'(bus.mem_req), 0);
    chk({tag, ".iack"}, 32'(bus.if_ack), 0);
    chk({tag, ".dack"}, 32'(bus.dm_ack), 0);
    chk({tag, ".err"},  32'(bus.err), 0);
  endtask

  // Called in the IDLE cycle where the request is first seen.
  task automatic run_txn(input string tag,
                         input logic own_dm,
                         input int waits,
                         input logic [31:0] rd,
                         input logic exp_err);
    logic [31:0] ea;
    logic        we;
    ea = own_dm ? bus.dm_addr : bus.if_addr;
    we = own_dm && bus.dm_we;
    for (int k = 0; k <= waits; k++) begin
      tick();
      chk({tag, ".mreq"}, 32'(bus.mem_req), 1);
      chk({tag, ".addr"}, bus.mem_addr, ea);
      chk({tag, ".we"},   32'(bus.mem_we), 32'(we));
      if (we) chk({tag, ".wdat"}, bus.mem_wdata, bus.dm_wdata);
      if (k == waits && !exp_err) begin
        bus.mem_ready = 1'b1;
        bus.mem_rdata = rd;
      end
    end
    tick();
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    if (!exp_err && !we) begin
      if (own_dm) exp_dm_rd = rd;
      else        exp_if_rd = rd;
    end
    chk({tag, ".iack"},  32'(bus.if_ack), 32'(!own_dm));
    chk({tag, ".dack"},  32'(bus.dm_ack), 32'(own_dm));
    chk({tag, ".err"},   32'(bus.err), 32'(exp_err));
    chk({tag, ".mreq0"}, 32'(bus.mem_req), 0);
    chk({tag, ".irdat"}, bus.if_rdata, exp_if_rd);
    chk({tag, ".drdat"}, bus.dm_rdata, exp_dm_rd);
  endtask

  initial begin
    bus.if_req    = 1'b0;
    bus.if_addr   = '0;
    bus.dm_req    = 1'b0;
    bus.dm_we     = 1'b0;
    bus.dm_addr   = '0;
    bus.dm_wdata  = '0;
    bus.mem_rdata = '0;
    bus.mem_ready = 1'b0;

    tick();
    tick();
    chk_quiet("rst");
    chk("rst.irdat", bus.if_rdata, 0);
    chk("rst.drdat", bus.dm_rdata, 0);
    chk("rst.addr",  bus.mem_addr, 0);
    rst = 1'b0;
    tick();

    bus.if_req  = 1'b1;
    bus.if_addr = 32'h0000_0100;
    run_txn("if_rd", 1'b0, 0, 32'h8C01_0004, 1'b0);
    bus.if_req = 1'b0;
    tick();
    chk_quiet("if_rd.idle");

    bus.dm_req   = 1'b1;
    bus.dm_we    = 1'b1;
    bus.dm_addr  = 32'h0000_0010;
    bus.dm_wdata = 32'hDEAD_BEEF;
    run_txn("dm_wr", 1'b1, 3, 32'h0, 1'b0);
    bus.dm_req = 1'b0;
    bus.dm_we  = 1'b0;
    tick();

    bus.if_req  = 1'b1;
    bus.if_addr = 32'h0000_0200;
    bus.dm_req  = 1'b1;
    bus.dm_addr = 32'h0000_0300;
    run_txn("sim_dm", 1'b1, 1, 32'h1111_2222, 1'b0);
    bus.dm_req = 1'b0;
    tick();
    run_txn("sim_if", 1'b0, 0, 32'h3333_4444, 1'b0);
    bus.if_req = 1'b0;
    tick();

    bus.if_req = 1'b1;
    bus.dm_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      run_txn($sformatf("starve%0d", i), (i % 5) != 4, i % 3,
              32'hA000_0000 + 32'(i), 1'b0);
      if (i == 9) begin
        bus.if_req = 1'b0;
        bus.dm_req = 1'b0;
      end
      tick();
    end

    bus.dm_req  = 1'b1;
    bus.dm_addr = 32'h0000_0040;
    run_txn("tmo", 1'b1, 15, 32'h0, 1'b1);
    bus.dm_req = 1'b0;
    tick();
    chk("tmo.err0", 32'(bus.err), 0);
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h0000_0104;
    run_txn("post_tmo", 1'b0, 2, 32'h5555_AAAA, 1'b0);
    bus.if_req = 1'b0;
    tick();

    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'h7777_7777;
    tick();
    tick();
    chk_quiet("rdy_idle");
    chk("rdy_idle.irdat", bus.if_rdata, exp_if_rd);
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;

    bus.if_req  = 1'b1;
    bus.if_addr = 32'h0000_0108;
    tick();
    chk("rst_busy.mreq", 32'(bus.mem_req), 1);
    tick();
    rst        = 1'b1;
    bus.if_req = 1'b0;
    tick();
    tick();
    rst       = 1'b0;
    exp_if_rd = '0;
    exp_dm_rd = '0;
    chk_quiet("rst_busy.a");
    bus.mem_ready = 1'b1;
    tick();
    chk_quiet("rst_busy.b");
    tick();
    chk_quiet("rst_busy.c");
    chk("rst_busy.irdat", bus.if_rdata, exp_if_rd);
    bus.mem_ready = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
